// File: rtl/decode_stage.sv
// RV32E instruction decode stage: one-entry skid buffer in front of a registered decoded bundle.
// Throughput is one instruction per cycle, and in_ready comes straight from a register.
module decode_stage #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [3:0]          out_class,
  output logic [IDX_BITS-1:0] out_rd,
  output logic [IDX_BITS-1:0] out_rs1,
  output logic [IDX_BITS-1:0] out_rs2,
  output logic [2:0]          out_funct3,
  output logic                out_alt,
  output logic [31:0]         out_imm,
  output logic                out_illegal
);

  localparam logic [3:0] ClsLui     = 4'd0;
  localparam logic [3:0] ClsAuipc   = 4'd1;
  localparam logic [3:0] ClsJal     = 4'd2;
  localparam logic [3:0] ClsJalr    = 4'd3;
  localparam logic [3:0] ClsBranch  = 4'd4;
  localparam logic [3:0] ClsLoad    = 4'd5;
  localparam logic [3:0] ClsStore   = 4'd6;
  localparam logic [3:0] ClsOpImm   = 4'd7;
  localparam logic [3:0] ClsOp      = 4'd8;
  localparam logic [3:0] ClsMiscMem = 4'd9;
  localparam logic [3:0] ClsSystem  = 4'd10;
  localparam logic [3:0] ClsIllegal = 4'd15;

  logic        r_skid_valid;
  logic [31:0] r_skid_data;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [3:0]  r_out_class;
  logic [IDX_BITS-1:0] r_out_rd, r_out_rs1, r_out_rs2;
  logic [2:0]  r_out_funct3;
  logic        r_out_alt;
  logic [31:0] r_out_imm;
  logic        r_out_illegal;

  logic        w_in_fire, w_out_free, w_load, w_skid_cap;
  logic        w_out_valid_nxt, w_skid_valid_nxt;
  logic [31:0] w_word;
  logic [4:0]  w_rd_f, w_rs1_f, w_rs2_f;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_use_rd, w_use_rs1, w_use_rs2, w_use_f3, w_bad, w_bad_reg, w_illegal;
  logic [3:0]  w_cls;
  logic        w_alt;
  logic [31:0] w_imm;
  logic [3:0]  w_dec_class;
  logic [IDX_BITS-1:0] w_dec_rd, w_dec_rs1, w_dec_rs2;
  logic [2:0]  w_dec_funct3;
  logic        w_dec_alt;
  logic [31:0] w_dec_imm;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_free = !r_out_valid || out_ready;
  // Skid contents always take precedence so ordering stays FIFO.
  assign w_word     = r_skid_valid ? r_skid_data : in_data;
  assign w_load     = w_out_free && (r_skid_valid || w_in_fire);
  assign w_skid_cap = !w_out_free && w_in_fire;

  assign w_rd_f  = w_word[11:7];
  assign w_rs1_f = w_word[19:15];
  assign w_rs2_f = w_word[24:20];
  assign w_f3    = w_word[14:12];
  assign w_f7    = w_word[31:25];

  assign w_imm_i = {{20{w_word[31]}}, w_word[31:20]};
  assign w_imm_s = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
  assign w_imm_b = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0};
  assign w_imm_u = {w_word[31:12], 12'b0};
  assign w_imm_j = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20], w_word[30:21], 1'b0};

  always_comb begin
    w_cls     = ClsIllegal;
    w_bad     = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_f3  = 1'b0;
    w_alt     = 1'b0;
    w_imm     = 32'd0;
    unique case (w_word[6:0])
      7'b0110111: begin w_cls = ClsLui;   w_use_rd = 1'b1; w_imm = w_imm_u; end
      7'b0010111: begin w_cls = ClsAuipc; w_use_rd = 1'b1; w_imm = w_imm_u; end
      7'b1101111: begin w_cls = ClsJal;   w_use_rd = 1'b1; w_imm = w_imm_j; end
      7'b1100111: begin
        w_cls = ClsJalr; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_i;
        w_bad = (w_f3 != 3'd0);
      end
      7'b1100011: begin
        w_cls = ClsBranch; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_b;
        w_bad = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      7'b0000011: begin
        w_cls = ClsLoad; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_i;
        w_bad = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      7'b0100011: begin
        w_cls = ClsStore; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_s;
        w_bad = (w_f3 >= 3'd3);
      end
      7'b0010011: begin
        w_cls = ClsOpImm; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_i;
        if (w_f3 == 3'd1) begin
          w_bad = (w_f7 != 7'h00);
        end else if (w_f3 == 3'd5) begin
          w_bad = (w_f7 != 7'h00) && (w_f7 != 7'h20);
          w_alt = w_word[30];
        end
      end
      7'b0110011: begin
        w_cls = ClsOp; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_f3 = 1'b1;
        w_alt = w_word[30];
        w_bad = !((w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
      end
      7'b0001111: begin
        w_cls = ClsMiscMem; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_i;
      end
      7'b1110011: begin
        w_cls = ClsSystem; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_f3 = 1'b1; w_imm = w_imm_i;
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_bad_reg = (w_use_rd  && (32'(w_rd_f)  >= NUM_REGS)) ||
                     (w_use_rs1 && (32'(w_rs1_f) >= NUM_REGS)) ||
                     (w_use_rs2 && (32'(w_rs2_f) >= NUM_REGS));
  assign w_illegal = w_bad || w_bad_reg;

  always_comb begin
    w_dec_class  = ClsIllegal;
    w_dec_rd     = '0;
    w_dec_rs1    = '0;
    w_dec_rs2    = '0;
    w_dec_funct3 = 3'd0;
    w_dec_alt    = 1'b0;
    w_dec_imm    = 32'd0;
    if (!w_illegal) begin
      w_dec_class  = w_cls;
      w_dec_rd     = w_use_rd  ? w_rd_f[IDX_BITS-1:0]  : '0;
      w_dec_rs1    = w_use_rs1 ? w_rs1_f[IDX_BITS-1:0] : '0;
      w_dec_rs2    = w_use_rs2 ? w_rs2_f[IDX_BITS-1:0] : '0;
      w_dec_funct3 = w_use_f3  ? w_f3 : 3'd0;
      w_dec_alt    = w_alt;
      w_dec_imm    = w_imm;
    end
  end

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      w_out_valid_nxt  = w_out_free ? (r_skid_valid || w_in_fire) : 1'b1;
      w_skid_valid_nxt = r_skid_valid ? !w_out_free : w_skid_cap;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_skid_valid  <= 1'b0;
      r_skid_data   <= 32'd0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_class   <= 4'd0;
      r_out_rd      <= '0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_funct3  <= 3'd0;
      r_out_alt     <= 1'b0;
      r_out_imm     <= 32'd0;
      r_out_illegal <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (!flush && w_skid_cap) begin
        r_skid_data <= in_data;
      end
      if (!flush && w_load) begin
        r_out_instr   <= w_word;
        r_out_class   <= w_dec_class;
        r_out_rd      <= w_dec_rd;
        r_out_rs1     <= w_dec_rs1;
        r_out_rs2     <= w_dec_rs2;
        r_out_funct3  <= w_dec_funct3;
        r_out_alt     <= w_dec_alt;
        r_out_imm     <= w_dec_imm;
        r_out_illegal <= w_illegal;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_class   = r_out_class;
  assign out_rd      = r_out_rd;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_funct3  = r_out_funct3;
  assign out_alt     = r_out_alt;
  assign out_imm     = r_out_imm;
  assign out_illegal = r_out_illegal;

endmodule
